// File: rtl/spi_peripheral.sv
// spi_peripheral
//
// Write-only SPI (mode 0) register front end for the PWM block. The three SPI
// pins are asynchronous to clk. Each pin goes through a synchroniser chain.
// sclk and ncs also have a history flop, which is used for edge detection.
// A frame is 16 bits, MSB first: {rw, addr[6:0], data[7:0]}. A frame is
// committed when ncs rises, and only if all of these hold:
//   - exactly 16 bits were clocked in,
//   - rw = 1,
//   - addr is a valid register address.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   sclk, copi, ncs  raw SPI pins (asynchronous)
//   en_reg_out_7_0   register 0x00
//   en_reg_out_15_8  register 0x01
//   en_reg_pwm_7_0   register 0x02
//   en_reg_pwm_15_8  register 0x03
//   pwm_duty_cycle   register 0x04
module spi_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam int NUM_REGS = 5;

  // Synchronisers. The ncs chain resets to 1 (idle), so that releasing reset
  // never produces a spurious edge on ncs.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_hist;
  logic                   ncs_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_hist <= 1'b0;
      ncs_hist  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      ncs_hist  <= ncs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic copi_s;
  logic ncs_s;
  logic sclk_rise;
  logic ncs_fall;
  logic ncs_rise;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign ncs_fall  = ~ncs_s & ncs_hist;
  assign ncs_rise  = ncs_s & ~ncs_hist;

  // Frame capture.
  logic [15:0] shift_reg;
  logic [4:0]  count_reg;
  logic        armed_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      count_reg <= '0;
      armed_reg <= 1'b0;
    end else if (ncs_fall) begin
      shift_reg <= '0;
      count_reg <= '0;
      armed_reg <= 1'b1;
    end else if (ncs_rise) begin
      // A sclk edge that coincides with ncs rising is deliberately dropped.
      // The commit decision therefore sees the count from before that edge.
      armed_reg <= 1'b0;
    end else if (armed_reg && !ncs_s && sclk_rise) begin
      shift_reg <= {shift_reg[14:0], copi_s};
      // Saturate at 17. Any long frame then stays distinguishable from a
      // 16-bit frame, however many extra bits arrive.
      if (count_reg < 5'd17) begin
        count_reg <= count_reg + 5'd1;
      end
    end
  end

  logic [6:0] frame_addr;
  logic       frame_ok;

  assign frame_addr = shift_reg[14:8];
  assign frame_ok   = armed_reg && (count_reg == 5'd16) && shift_reg[15] &&
                      (frame_addr <= MAX_ADDR) && (frame_addr < 7'(NUM_REGS));

  // The accept decision is registered and then applied one cycle later. This
  // gives SYNC_STAGES+1 edges of latency from the edge that first samples ncs
  // high.
  logic       wr_en_reg;
  logic [2:0] wr_sel_reg;
  logic [7:0] wr_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_reg   <= 1'b0;
      wr_sel_reg  <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg   <= ncs_rise && frame_ok;
      wr_sel_reg  <= frame_addr[2:0];
      wr_data_reg <= shift_reg[7:0];
    end
  end

  // Register bank: one flop group per address.
  logic [7:0] bank [NUM_REGS];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bank[gi] <= '0;
        end else if (wr_en_reg && (wr_sel_reg == 3'(gi))) begin
          bank[gi] <= wr_data_reg;
        end
      end
    end
  endgenerate

  assign en_reg_out_7_0  = bank[0];
  assign en_reg_out_15_8 = bank[1];
  assign en_reg_pwm_7_0  = bank[2];
  assign en_reg_pwm_15_8 = bank[3];
  assign pwm_duty_cycle  = bank[4];

endmodule

// File: tb/tb_spi_peripheral.sv
// Testbench for spi_peripheral.
// Directed SPI frames are sent with hand-computed expected register states.
// Each frame queues two scheduled checks:
//   - the register state one cycle before the commit edge (old values),
//   - the register state on the commit edge (new values).
// A separate monitor pops and compares each entry on the cycle it is due.
module tb_spi_peripheral;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  spi_peripheral dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [39:0] exp;
    string       name;
  } chk_t;

  typedef struct {
    logic [16:0] bits;
    int          nbits;
    logic [39:0] exp;
    string       name;
  } vec_t;

  chk_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [39:0] exp_state;
  logic [39:0] dut_vec;

  assign dut_vec = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
                    en_reg_pwm_15_8, pwm_duty_cycle};

  // Monitor: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      checks++;
      if (sb_q[0].due < cyc) begin
        errors++;
        $display("FAIL %s: check missed (due cycle %0d, now %0d)",
                 sb_q[0].name, sb_q[0].due, cyc);
      end else if (dut_vec !== sb_q[0].exp) begin
        errors++;
        $display("FAIL %s: got %h required %h", sb_q[0].name, dut_vec, sb_q[0].exp);
      end else begin
        $display("ok   %s: %h @cycle %0d", sb_q[0].name, dut_vec, cyc);
      end
      void'(sb_q.pop_front());
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_chk(input int due, input logic [39:0] exp, input string name);
    chk_t c;
    c.due  = due;
    c.exp  = exp;
    c.name = name;
    sb_q.push_back(c);
  endtask

  task automatic frame_start();
    ncs = 1'b0;
    wait_clk(4);
  endtask

  task automatic send_bits(input logic [16:0] bits, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = bits[i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  // Raise ncs. The commit must appear exactly on the 3rd edge after the
  // first edge that samples ncs high; the edge before it still shows old data.
  task automatic frame_end(input logic [39:0] exp_new, input string name);
    int d;
    wait_clk(4);
    ncs = 1'b1;
    d = cyc;
    push_chk(d + 3, exp_state, {name, " hold"});
    push_chk(d + 4, exp_new, name);
    exp_state = exp_new;
    wait_clk(4);
  endtask

  task automatic run_vec(input vec_t v);
    frame_start();
    send_bits(v.bits, v.nbits);
    frame_end(v.exp, v.name);
  endtask

  vec_t vecs[10];

  initial begin
    // Expected state layout: {reg0, reg1, reg2, reg3, reg4}.
    vecs[0] = '{17'h080F0, 16, 40'hF0_00_00_00_00, "wr a0=F0"};
    vecs[1] = '{17'h08480, 16, 40'hF0_00_00_00_80, "wr a4=80"};
    vecs[2] = '{17'h00155, 16, 40'hF0_00_00_00_80, "rej read"};
    vecs[3] = '{17'h08555, 16, 40'hF0_00_00_00_80, "rej addr5"};
    vecs[4] = '{17'h040D5, 15, 40'hF0_00_00_00_80, "rej 15bit"};
    vecs[5] = '{17'h10355, 17, 40'hF0_00_00_00_80, "rej 17bit"};
    vecs[6] = '{17'h081AA, 16, 40'hF0_AA_00_00_80, "b2b a1=AA"};
    vecs[7] = '{17'h08255, 16, 40'hF0_AA_55_00_80, "b2b a2=55"};
    vecs[8] = '{17'h083FF, 16, 40'hF0_AA_55_FF_80, "b2b a3=FF"};
    vecs[9] = '{17'h0823C, 16, 40'h00_00_3C_00_00, "post-rst a2=3C"};

    rst_n     = 1'b0;
    sclk      = 1'b0;
    copi      = 1'b0;
    ncs       = 1'b1;
    exp_state = '0;
    wait_clk(5);
    push_chk(cyc + 1, 40'h0, "reset state");
    rst_n = 1'b1;
    wait_clk(2);

    // Idle for 100 cycles: ncs high, sclk toggling.
    for (int i = 0; i < 25; i++) begin
      sclk = ~sclk;
      copi = 1'($urandom_range(0, 1));
      push_chk(cyc + 2, 40'h0, "idle");
      wait_clk(4);
    end
    sclk = 1'b0;
    wait_clk(4);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset in the middle of a write to 0x02; the frame must be dropped.
    frame_start();
    send_bits(17'h00082, 8);
    rst_n = 1'b0;
    exp_state = '0;
    wait_clk(3);
    push_chk(cyc + 1, 40'h0, "in reset");
    rst_n = 1'b1;
    wait_clk(2);
    send_bits(17'h00077, 8);
    frame_end(40'h00_00_00_00_00, "rej cut by reset");
    run_vec(vecs[9]);

    // sclk activity with ncs high must not disturb the next frame.
    for (int i = 0; i < 6; i++) begin
      sclk = ~sclk;
      copi = ~copi;
      wait_clk(4);
    end
    sclk = 1'b0;
    wait_clk(4);
    frame_start();
    send_bits(17'h08381, 16);
    frame_end(40'h00_00_3C_81_00, "wr a3=81 after idle sclk");

    // Drain the scoreboard within a bounded time.
    for (int i = 0; i < 50 && sb_q.size() > 0; i++) wait_clk(1);
    while (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never checked (due cycle %0d, now %0d)",
               sb_q[0].name, sb_q[0].due, cyc);
      void'(sb_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
